// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults, reset config, config bundle and length mask for seq_detector_prog
package seq_det_pkg;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W = $clog2(DEF_MAX_LEN + 1);
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_MAX_LEN-1:0] DEF_RST_PATTERN = 8'b0000_1011;
  localparam int DEF_RST_LEN = 4;
  localparam bit DEF_RST_OVERLAP = 1'b1;
  typedef struct packed {
    logic [DEF_MAX_LEN-1:0] pattern;
    logic [DEF_LEN_W-1:0]   len;
    logic                   overlap;
  } cfg_t;
  function automatic logic [DEF_MAX_LEN-1:0] len_mask(input logic [DEF_LEN_W-1:0] len);
    logic [DEF_MAX_LEN-1:0] m;
    for (int i = 0; i < DEF_MAX_LEN; i++) m[i] = (i < int'(len));
    return m;
  endfunction
endpackage

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: W-bit saturating up-counter, sync clear has priority over increment
//   clk, rst (async, active-high) | i_inc: count one | i_clr: clear to 0 | o_cnt: count
module seq_det_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign o_cnt = r_cnt;
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector with overlap mode and match counter
//   clk, rst (async, active-high)
//   in, in_valid: serial bit and its qualifier
//   cfg_we, cfg_pattern, cfg_len, cfg_overlap: config write (pattern bit [len-1] arrives first)
//   cnt_clr: sync clear of match_cnt
//   match: registered one-cycle pulse | match_cnt: saturating count | cfg_err: rejected config write
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                   MAX_LEN     = DEF_MAX_LEN,
  parameter int                   LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                   CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = DEF_RST_PATTERN,
  parameter int                   RST_LEN     = DEF_RST_LEN,
  parameter bit                   RST_OVERLAP = DEF_RST_OVERLAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);
  localparam cfg_t RST_CFG = '{RST_PATTERN, LEN_W'(RST_LEN), RST_OVERLAP};
  cfg_t               r_cfg;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;
  logic               r_cfg_err;
  logic [MAX_LEN-1:0] w_new_hist;
  logic [LEN_W-1:0]   w_new_fill;
  logic               w_cfg_ok;
  logic               w_hit;
  assign w_new_hist = {r_hist[MAX_LEN-2:0], in};
  assign w_new_fill = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
  assign w_cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  // fill masks stale history bits, so a flush only needs to zero the counter
  assign w_hit = in_valid && !cfg_we && (w_new_fill >= r_cfg.len) &&
                 (((w_new_hist ^ r_cfg.pattern) & len_mask(r_cfg.len)) == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg     <= RST_CFG;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_hit;
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (cfg_we) begin
        if (w_cfg_ok) begin
          r_cfg  <= '{cfg_pattern, cfg_len, cfg_overlap};
          r_fill <= '0;
        end
      end else if (in_valid) begin
        r_hist <= w_new_hist;
        r_fill <= (w_hit && !r_cfg.overlap) ? '0 : w_new_fill;
      end
    end
  end
  seq_det_sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_hit),
    .i_clr (cnt_clr),
    .o_cnt (match_cnt)
  );
  assign match   = r_match;
  assign cfg_err = r_cfg_err;
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: vector table, corner sequences and random stream against a queue-based model
module tb_seq_detector_prog;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_in = 1'b0, d_v = 1'b0, d_we = 1'b0, d_ov = 1'b0, d_clr = 1'b0;
  logic [7:0]  d_pat = '0;
  logic [3:0]  d_len = '0;
  logic        match, cfg_err, match2, err2;
  logic [15:0] match_cnt;
  logic [1:0]  cnt2;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk(clk), .rst(rst), .in(d_in), .in_valid(d_v), .cfg_we(d_we), .cfg_pattern(d_pat),
    .cfg_len(d_len), .cfg_overlap(d_ov), .cnt_clr(d_clr), .match(match), .match_cnt(match_cnt),
    .cfg_err(cfg_err)
  );
  seq_detector_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in(d_in), .in_valid(d_v), .cfg_we(d_we), .cfg_pattern(d_pat),
    .cfg_len(d_len), .cfg_overlap(d_ov), .cnt_clr(d_clr), .match(match2), .match_cnt(cnt2),
    .cfg_err(err2)
  );

  // reference model: the bits seen since the last flush, newest at the back
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len, m_cnt, m_cnt2;
  bit         m_ov, m_match, m_err;

  task automatic model_reset();
    mq.delete();
    m_pat = 8'h0B; m_len = 4; m_ov = 1'b1;
    m_cnt = 0; m_cnt2 = 0; m_match = 1'b0; m_err = 1'b0;
  endtask

  task automatic model(input bit v, b, we, input logic [7:0] p, input int l, input bit o, c);
    bit hit = 1'b0;
    bit legal = (l >= 1 && l <= 8);
    m_err = we && !legal;
    if (we) begin
      if (legal) begin m_pat = p; m_len = l; m_ov = o; mq.delete(); end
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > 8) void'(mq.pop_front());
      if (mq.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++) if (mq[mq.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ov) mq.delete();
    end
    m_match = hit;
    if (c) begin m_cnt = 0; m_cnt2 = 0; end
    else if (hit) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, b, we, input logic [7:0] p, input int l, input bit o, c);
    d_v = v; d_in = b; d_we = we; d_pat = p; d_len = l[3:0]; d_ov = o; d_clr = c;
    @(posedge clk);
    model(v, b, we, p, l, o, c);
    #1;
    chk("model match", match, m_match);
    chk("model cnt", match_cnt, m_cnt);
    chk("model cfg_err", cfg_err, m_err);
    chk("model match2", match2, m_match);
    chk("model cnt2", cnt2, m_cnt2);
    d_v = 1'b0; d_we = 1'b0; d_clr = 1'b0;
  endtask

  typedef struct {
    bit v, b, we;
    logic [7:0] p;
    int l;
    bit o, c, em, ee;
    int ec;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit v, b, we, logic [7:0] p, int l, bit o, c, em, ee, int ec);
    tbl.push_back('{v, b, we, p, l, o, c, em, ee, ec});
  endfunction
  function automatic void bv(bit b, em, int ec);
    add(1, b, 0, 8'h00, 0, 0, 0, em, 0, ec);
  endfunction
  function automatic void cf(logic [7:0] p, int l, bit o, ee, int ec);
    add(0, 0, 1, p, l, o, 0, 0, ee, ec);
  endfunction
  function automatic void gap(int ec);
    add(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, ec);
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset match", match, 0);
    chk("reset cnt", match_cnt, 0);
    chk("reset cfg_err", cfg_err, 0);
    rst = 1'b0;

    // reset config, overlapping
    bv(1,0,0); bv(0,0,0); bv(1,0,0); bv(1,1,1); bv(0,0,1); bv(1,0,1); bv(1,1,2);
    // same pattern, non-overlapping
    cf(8'h0B, 4, 0, 0, 2);
    bv(1,0,2); bv(0,0,2); bv(1,0,2); bv(1,1,3); bv(0,0,3); bv(1,0,3); bv(1,0,3);
    // full-length pattern, then two illegal lengths that must leave it intact
    cf(8'hF0, 8, 1, 0, 3);
    bv(1,0,3); bv(1,0,3); bv(1,0,3); bv(1,0,3); bv(0,0,3); bv(0,0,3); bv(0,0,3); bv(0,1,4);
    cf(8'h00, 0, 0, 1, 4);
    cf(8'h00, 9, 0, 1, 4);
    bv(1,0,4); bv(1,0,4); bv(1,0,4); bv(1,0,4); bv(0,0,4); bv(0,0,4); bv(0,0,4); bv(0,1,5);
    // cfg write on a valid bit discards it and flushes
    cf(8'h03, 2, 1, 0, 5);
    bv(1,0,5); bv(1,1,6);
    add(1, 1, 1, 8'h03, 2, 1, 0, 0, 0, 6);
    bv(1,0,6); bv(1,1,7);
    // gaps of in_valid=0 are transparent
    cf(8'h0B, 4, 1, 0, 7);
    bv(1,0,7); gap(7); gap(7); gap(7);
    bv(0,0,7); gap(7); gap(7); gap(7);
    bv(1,0,7); gap(7); gap(7); gap(7);
    bv(1,1,8); gap(8); gap(8);
    // len 1, non-overlap, upper pattern bits ignored
    cf(8'hAB, 1, 0, 0, 8);
    bv(1,1,9); bv(1,1,10); bv(0,0,10); bv(1,1,11);
    // clear wins over a coincident match
    add(1, 1, 0, 8'h00, 0, 0, 1, 1, 0, 0);
    bv(1,1,1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].b, tbl[i].we, tbl[i].p, tbl[i].l, tbl[i].o, tbl[i].c);
      chk($sformatf("tbl%0d match", i), match, tbl[i].em);
      chk($sformatf("tbl%0d cfg_err", i), cfg_err, tbl[i].ee);
      chk($sformatf("tbl%0d cnt", i), match_cnt, tbl[i].ec);
    end

    // 2-bit counter saturation, still len 1 pattern 1 non-overlap
    step(0, 0, 0, 8'h00, 0, 0, 1);
    chk("sat clr", cnt2, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 8'h00, 0, 0, 0);
      chk($sformatf("sat cnt2 %0d", i), cnt2, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat match2 %0d", i), match2, 1);
    end
    step(1, 1, 0, 8'h00, 0, 0, 1);
    chk("sat clr+match cnt2", cnt2, 0);
    chk("sat clr+match match2", match2, 1);

    // async reset right after a match, with a non-reset config loaded
    step(0, 0, 1, 8'h0B, 4, 0, 0);
    step(1, 1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 0);
    step(1, 1, 0, 8'h00, 0, 0, 0);
    step(1, 1, 0, 8'h00, 0, 0, 0);
    chk("pre-rst match", match, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst match", match, 0);
    chk("async rst cnt", match_cnt, 0);
    chk("async rst cnt2", cnt2, 0);
    chk("async rst match2", match2, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    // leftover history 1011 must not complete a match with 0,1,1; reset config is overlapping
    step(1, 0, 0, 8'h00, 0, 0, 0);
    step(1, 1, 0, 8'h00, 0, 0, 0);
    step(1, 1, 0, 8'h00, 0, 0, 0);
    chk("post-rst no early match", match, 0);
    step(1, 0, 0, 8'h00, 0, 0, 0);
    step(1, 1, 0, 8'h00, 0, 0, 0);
    step(1, 1, 0, 8'h00, 0, 0, 0);
    chk("post-rst match", match, 1);

    // random stream against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 39) == 0,
           8'($urandom), $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
